l2_line_responder: RTL
======================

# l2_line_responder

Second-level responder for the L1 data cache's line-refill protocol. When L1 stalls on a read miss, this block looks up its own direct-mapped L2 array, fetches the line from main memory on an L2 miss, and streams the four words of the line to L1 through the `counter`/`l2_word` pair, then signals completion. It sits between L1 and the main-memory port and keeps L2 coherent with L1 write-hits.

## Interface
- `SETS_LOG2`, default 4: log2 of the number of L2 sets, range 2..8.
- `clk`  in  1  clock, all state rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `l1_req`  in  1  L1 refill request; this is L1's stall output (read and L1 miss).
- `l1_addr`  in  32  word address. Offset = [1:0]; L2 index = [SETS_LOG2+1:2]; L2 tag = [31:SETS_LOG2+2].
- `l1_wr`  in  1  L1 write-hit strobe for write-through update.
- `l1_wdata`  in  32  write data, at word `l1_addr[1:0]`.
- `l2_word`  out  32  refill word.
- `counter`  out  3  refill phase: 0 idle, 1..4 word valid, 5 line complete.
- `mem_req`  out  1  main-memory line read request.
- `mem_addr`  out  32  line-aligned address `{l1_addr[31:2],2'b00}`.
- `mem_ready`  in  1  one-cycle strobe; `mem_rdata` valid.
- `mem_rdata`  in  128  line; word 0 = [127:96], word 3 = [31:0].

## Operation
- Array: 2^SETS_LOG2 entries of {valid, tag, 128-bit data}. A 128-bit line buffer holds the line being streamed.
- FSM states: IDLE, LOOKUP, MEM_WAIT, STREAM, DONE, HOLD.
- IDLE: `counter`=0. `l1_req`=1 latches `l1_addr` into the request register and moves to LOOKUP.
- LOOKUP: compares the tag. On a hit, copies the array line to the line buffer and moves to STREAM. On a miss, moves to MEM_WAIT.
- MEM_WAIT: `mem_req`=1 and `mem_addr` are held stable until `mem_ready`. On `mem_ready`:
  - writes the line to the array (valid=1, new tag);
  - copies the line to the line buffer;
  - moves to STREAM.
- STREAM: `counter` runs 1,2,3,4 on consecutive cycles. `l2_word` = buffer word `(offset + counter - 1) mod 4`, using 2-bit wrap, so the critical word goes first.
- DONE: `counter`=5 for exactly one cycle; `l2_word` = buffer word `offset` (don't-care for L1). Then moves to HOLD.
- HOLD: `counter`=0 for one cycle and `l1_req` is ignored. Then moves to IDLE. This gives L1 time to drop its stall after setting valid.
- Abort: `l1_req`=0 during LOOKUP, STREAM or DONE returns the FSM to IDLE with `counter`=0 on the next edge.
  - In MEM_WAIT, the memory transaction always completes and the array is filled, but streaming is skipped (goes to HOLD).
- Write-through: `l1_wr` with an L2 tag hit updates the addressed array word in any state.
  - If `l1_wr` targets the line in MEM_WAIT, the written word overrides the corresponding `mem_rdata` word at fill time.
  - A write and a fill to the same set in the same edge: the merged fill wins.
  - A write to a missing line is dropped (no-write-allocate).
- The memory write-back path is outside this block.

## Timing
- Reset values: `counter`=0, `l2_word`=0, `mem_req`=0, `mem_addr`=0, FSM=IDLE, all valid bits 0. Reset mid-transfer abandons the transfer; `mem_req` drops asynchronously.
- L2 hit: request seen at edge T → LOOKUP T+1 → `counter`=1 at T+2 … 4 at T+5, 5 at T+6, 0 at T+7. Earliest next accept is T+8.
- L2 miss: `mem_req` rises at T+2. With `mem_ready` sampled at edge M, `counter`=1 at M+1 and 5 at M+5.
- `mem_ready` outside MEM_WAIT is ignored.
- Outputs are registered; there is no combinational path from inputs to `counter`/`l2_word`.

## Configuration
- `L2_PERF_CNT_EN` defined: adds outputs `hit_cnt` and `miss_cnt` (32 bits each, reset 0, saturating).
  - They increment in LOOKUP on a hit or miss respectively; aborted requests are still counted.
- Not defined: these ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Cold miss: reset; `l1_req`=1, `l1_addr`=0x0000_0012; `mem_ready` 3 cycles after `mem_req`, `mem_rdata`=0xA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3.
  - Required: `mem_addr`=0x10; words C2…, D3…, A0…, B1… with `counter` 1..4; then `counter`=5, then 0.
- Warm hit: repeat the request to 0x0000_0010 → no `mem_req`; `counter`=1 two cycles after the request, words A0, B1, C2, D3.
- Write-through: `l1_wr` to 0x11, `l1_wdata`=0xDEADBEEF; then re-request 0x10 → second streamed word = 0xDEADBEEF.
- Conflict eviction (SETS_LOG2=4): fill 0x10, then request 0x50 → miss, `mem_addr`=0x50; a re-request to 0x10 then misses again.
- Abort and write-merge in MEM_WAIT: drop `l1_req` while waiting and `l1_wr` to that line's word 0 = 0x1234.
  - Required: `mem_req` held until `mem_ready`; no `counter` 1..4; a later hit returns word 0 = 0x1234.
- Async reset asserted at `counter`=2 → `counter`=0 and `mem_req`=0 immediately; the following request to the same line misses.

Source files
------------

// File: rtl/l2_line_responder_if.sv
// L1 refill handshake and main-memory line-read signals of the L2 line responder.
interface l2_line_responder_if;
    logic         l1_req;
    logic [31:0]  l1_addr;
    logic         l1_wr;
    logic [31:0]  l1_wdata;
    logic [31:0]  l2_word;
    logic [2:0]   counter;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ready;
    logic [127:0] mem_rdata;

    modport master (
        output l1_req, l1_addr, l1_wr, l1_wdata, mem_ready, mem_rdata,
        input  l2_word, counter, mem_req, mem_addr
    );

    modport slave (
        input  l1_req, l1_addr, l1_wr, l1_wdata, mem_ready, mem_rdata,
        output l2_word, counter, mem_req, mem_addr
    );
endinterface

// File: rtl/l2_line_responder.sv
// Direct-mapped L2 that refills L1 lines critical-word-first and stays coherent with L1 write hits.
// Optional macro L2_PERF_CNT_EN adds saturating hit_cnt/miss_cnt outputs.
module l2_line_responder #(
    parameter int unsigned SETS_LOG2 = 4
) (
    input  logic clk,
    input  logic rst,
    l2_line_responder_if.slave bus
`ifdef L2_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int unsigned SETS  = 1 << SETS_LOG2;
    localparam int unsigned TAG_W = 30 - SETS_LOG2;

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_WAIT, STREAM, DONE, HOLD} state_t;

    state_t              state;
    logic [31:0]         req_addr;
    logic [127:0]        line_buf;
    logic [SETS-1:0]     valid_q;
    logic [TAG_W-1:0]    tag_arr [SETS];
    logic [127:0]        data_arr [SETS];
    logic [3:0]          ovr_mask;
    logic [31:0]         ovr_data [4];
    logic                aborted;

    logic [SETS_LOG2-1:0] req_idx, wr_idx;
    logic [TAG_W-1:0]     req_tag, wr_tag;
    logic [1:0]           req_off, wr_off, stream_sel;
    logic                 lookup_hit, wr_hit, fill_en, wr_to_pending;
    logic [31:0]          fill_w [4];
    logic [127:0]         fill_line;

    function automatic logic [31:0] word_of(input logic [127:0] line, input logic [1:0] w);
        case (w)
            2'd0:    word_of = line[127:96];
            2'd1:    word_of = line[95:64];
            2'd2:    word_of = line[63:32];
            default: word_of = line[31:0];
        endcase
    endfunction

    assign req_idx    = req_addr[SETS_LOG2+1:2];
    assign req_tag    = req_addr[31:SETS_LOG2+2];
    assign req_off    = req_addr[1:0];
    assign wr_idx     = bus.l1_addr[SETS_LOG2+1:2];
    assign wr_tag     = bus.l1_addr[31:SETS_LOG2+2];
    assign wr_off     = bus.l1_addr[1:0];
    assign stream_sel = req_off + bus.counter[1:0];

    assign lookup_hit    = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
    assign wr_hit        = bus.l1_wr && valid_q[wr_idx] && (tag_arr[wr_idx] == wr_tag);
    assign fill_en       = (state == MEM_WAIT) && bus.mem_ready;
    assign wr_to_pending = bus.l1_wr && (state == MEM_WAIT) && (bus.l1_addr[31:2] == req_addr[31:2]);

    // Writes seen while the line is in flight, including one on the fill edge, override memory data.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            fill_w[i] = ovr_mask[i] ? ovr_data[i] : word_of(bus.mem_rdata, 2'(i));
            if (wr_to_pending && (wr_off == 2'(i)))
                fill_w[i] = bus.l1_wdata;
        end
    end
    assign fill_line = {fill_w[0], fill_w[1], fill_w[2], fill_w[3]};

    // Fill is assigned last so it wins over a write-through hit to the same set.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            case (wr_off)
                2'd0:    data_arr[wr_idx][127:96] <= bus.l1_wdata;
                2'd1:    data_arr[wr_idx][95:64]  <= bus.l1_wdata;
                2'd2:    data_arr[wr_idx][63:32]  <= bus.l1_wdata;
                default: data_arr[wr_idx][31:0]   <= bus.l1_wdata;
            endcase
        end
        if (fill_en) begin
            data_arr[req_idx] <= fill_line;
            tag_arr[req_idx]  <= req_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid_q <= '0;
        else if (fill_en)
            valid_q[req_idx] <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_addr     <= '0;
            line_buf     <= '0;
            bus.counter  <= '0;
            bus.l2_word  <= '0;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
            ovr_mask     <= '0;
            ovr_data     <= '{default: '0};
            aborted      <= 1'b0;
`ifdef L2_PERF_CNT_EN
            hit_cnt      <= '0;
            miss_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.counter <= '0;
                    if (bus.l1_req) begin
                        req_addr <= bus.l1_addr;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    ovr_mask <= '0;
                    aborted  <= 1'b0;
`ifdef L2_PERF_CNT_EN
                    if (lookup_hit && (hit_cnt != '1))
                        hit_cnt <= hit_cnt + 32'd1;
                    if (!lookup_hit && (miss_cnt != '1))
                        miss_cnt <= miss_cnt + 32'd1;
`endif
                    if (!bus.l1_req) begin
                        state <= IDLE;
                    end else if (lookup_hit) begin
                        line_buf    <= data_arr[req_idx];
                        bus.counter <= 3'd1;
                        bus.l2_word <= word_of(data_arr[req_idx], req_off);
                        state       <= STREAM;
                    end else begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= {req_addr[31:2], 2'b00};
                        state        <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (wr_to_pending) begin
                        ovr_mask[wr_off] <= 1'b1;
                        ovr_data[wr_off] <= bus.l1_wdata;
                    end
                    if (!bus.l1_req)
                        aborted <= 1'b1;
                    if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        line_buf    <= fill_line;
                        if (aborted || !bus.l1_req) begin
                            state <= HOLD;
                        end else begin
                            bus.counter <= 3'd1;
                            bus.l2_word <= word_of(fill_line, req_off);
                            state       <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (!bus.l1_req) begin
                        bus.counter <= '0;
                        state       <= IDLE;
                    end else if (bus.counter == 3'd4) begin
                        bus.counter <= 3'd5;
                        bus.l2_word <= word_of(line_buf, req_off);
                        state       <= DONE;
                    end else begin
                        bus.counter <= bus.counter + 3'd1;
                        bus.l2_word <= word_of(line_buf, stream_sel);
                    end
                end
                DONE: begin
                    bus.counter <= '0;
                    state       <= bus.l1_req ? HOLD : IDLE;
                end
                HOLD: begin
                    bus.counter <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
